// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: in-order instruction buffer between fetch and decode.
// Latency: 1 cycle enqueue-to-out_valid; 0 cycles when FETCH_IQ_BYPASS_EN is defined and the queue is empty.
// Backpressure: in_ready drops when full, under flush, or under reset; head outputs hold while out_ready is low.

`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_inst_queue #(
  parameter int ADDR  = `AddrWidth,
  parameter int INST  = `InstWidth,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR-1:0]            in_pc,
  input  logic [INST-1:0]            in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR-1:0]            out_pc,
  output logic [INST-1:0]            out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Pointer wrap relies on DEPTH being a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_inst_queue: DEPTH must be a power of two, at least 2");
  end

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [INST-1:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty;
  logic            push, pop;
  logic            pass_through;
`ifdef FETCH_IQ_BYPASS_EN
  logic            bypass;
`endif

  // Handshake decode, head selection and next-state for pointers/count.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    in_ready = !full && !flush && !reset;
    head     = mem_q[rd_ptr_q];
`ifdef FETCH_IQ_BYPASS_EN
    // An empty queue forwards the incoming entry straight to decode.
    bypass       = empty && in_valid && !flush && !reset;
    out_valid    = !empty || bypass;
    out_pc       = bypass ? in_pc   : head.pc;
    out_inst     = bypass ? in_inst : head.inst;
    pass_through = bypass && out_ready;
`else
    out_valid    = !empty;
    out_pc       = head.pc;
    out_inst     = head.inst;
    pass_through = 1'b0;
`endif
    // A passed-through entry is never stored; a dequeue from an empty
    // queue can only be that pass-through, so it must not move rd_ptr.
    push = in_valid && in_ready && !pass_through;
    pop  = out_valid && out_ready && !empty;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state; reset outranks flush, both empty the queue outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are left unreset, push is already gated by flush/reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, inst: in_inst};
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
module tb_fetch_inst_queue;

  localparam int ADDR  = 32;
  localparam int INST  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [ADDR-1:0] in_pc, out_pc;
  logic [INST-1:0] in_inst, out_inst;
  logic [CW-1:0]   count;

  int checks   = 0;
  int failures = 0;

  fetch_inst_queue #(.ADDR(ADDR), .INST(INST), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [INST-1:0] mk_inst(input logic [ADDR-1:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [ADDR-1:0] pc, input logic [INST-1:0] inst);
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during got=%b exp=0", in_ready); end
    reset = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(4*i); in_inst = mk_inst(in_pc);
      #1;
      checks++;
      if (in_ready !== (i < 8)) begin failures++; $display("FAIL fill_in_ready i=%0d got=%b exp=%b", i, in_ready, (i < 8)); end
      tick();
      checks++;
      if (count !== CW'((i < 8) ? i + 1 : 8)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, (i < 8) ? i + 1 : 8); end
    end
    checks++; if (out_pc !== 32'h1000) begin failures++; $display("FAIL fill_head got=%h exp=1000", out_pc); end
  endtask

  // Starts from the full queue left by test_fill.
  task automatic test_drain_wrap();
    int nin = 0;
    logic accepted;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (nin < 4); in_pc = 32'h1020 + 32'(4*nin); in_inst = mk_inst(in_pc);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(4*cyc) || out_inst !== mk_inst(32'h1000 + 32'(4*cyc))) begin
        failures++;
        $display("FAIL drain_out cyc=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h", cyc, out_valid, out_pc, out_inst, 32'h1000 + 32'(4*cyc));
      end
      checks++;
      if (in_ready !== (cyc != 0)) begin failures++; $display("FAIL drain_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (cyc != 0)); end
      accepted = in_valid && in_ready;
      tick();
      if (accepted) nin++;
    end
    in_valid = 1'b0; out_ready = 1'b0; #1;
    checks++; if (nin != 4) begin failures++; $display("FAIL drain_accepted got=%0d exp=4", nin); end
    checks++; if (count !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL drain_end got count=%0d v=%b exp count=0 v=0", count, out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h1100 + 32'(4*i), mk_inst(32'h1100 + 32'(4*i)));
    checks++; if (count !== CW'(3)) begin failures++; $display("FAIL b2b_prefill got=%0d exp=3", count); end
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_pc = 32'h110C + 32'(4*k); in_inst = mk_inst(in_pc);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1100 + 32'(4*k)) begin failures++; $display("FAIL b2b_out k=%0d got v=%b pc=%h exp pc=%h", k, out_valid, out_pc, 32'h1100 + 32'(4*k)); end
      tick();
      checks++;
      if (count !== CW'(3)) begin failures++; $display("FAIL b2b_count k=%0d got=%0d exp=3", k, count); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    push(32'h2000, 32'h0000_0013);
    push(32'h2004, 32'h0010_0093);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h2000 || out_inst !== 32'h0000_0013) begin
        failures++; $display("FAIL bp_hold k=%0d got v=%b pc=%h inst=%h exp pc=2000 inst=00000013", k, out_valid, out_pc, out_inst);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h2004 || out_inst !== 32'h0010_0093) begin
      failures++; $display("FAIL bp_next got v=%b pc=%h inst=%h exp pc=2004 inst=00100093", out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) push(32'h1200 + 32'(4*i), mk_inst(32'h1200 + 32'(4*i)));
    checks++; if (count !== CW'(5)) begin failures++; $display("FAIL flush_prefill got=%0d exp=5", count); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h3000; in_inst = mk_inst(32'h3000); out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || count !== '0) begin failures++; $display("FAIL flush_empty got v=%b count=%0d exp v=0 count=0", out_valid, count); end
    push(32'h4000, mk_inst(32'h4000));
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4000 || count !== CW'(1)) begin
      failures++; $display("FAIL flush_next got v=%b pc=%h count=%0d exp v=1 pc=4000 count=1", out_valid, out_pc, count);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid = 1'b1; in_pc = 32'h5000; in_inst = mk_inst(32'h5000); out_ready = 1'b1;
    #1;
`ifdef FETCH_IQ_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h5000) begin failures++; $display("FAIL bypass_same got v=%b pc=%h exp v=1 pc=5000", out_valid, out_pc); end
    tick();
    in_valid = 1'b0; #1;
    checks++; if (count !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL bypass_after got count=%0d v=%b exp count=0 v=0", count, out_valid); end
`else
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_same got v=%b exp v=0", out_valid); end
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h5000 || count !== CW'(1)) begin failures++; $display("FAIL nobypass_next got v=%b pc=%h count=%0d exp v=1 pc=5000 count=1", out_valid, out_pc, count); end
    tick();
    checks++; if (count !== '0 || out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_drain got count=%0d v=%b exp 0/0", count, out_valid); end
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
